conv_accum: RTL and testbench



---
 rtl/conv_accum_pkg.sv | 12 +
 rtl/conv_accum_sat_relu.sv | 38 +++
 rtl/conv_accum.sv | 80 ++++++++
 tb/tb_conv_accum.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_accum_pkg.sv
// Shared datapath constants and types for the convolution output path.
// Provides NBITS (CSA sum width), output/channel defaults and acc_t.
package packConv;

  localparam int NBITS     = 16;
  localparam int OBITS_DEF = 8;
  localparam int NCH_DEF   = 4;
  localparam int ACCW_DEF  = NBITS + $clog2(NCH_DEF + 1);

  typedef logic signed [ACCW_DEF-1:0] acc_t;

endpackage

// File: rtl/conv_accum_sat_relu.sv
// Combinational post-processing: optional ReLU then signed saturation.
// Ports: val (ACCW signed), relu_en -> res (OBITS signed), sat (clipped).
module sat_relu
  import packConv::*;
#(
  parameter int ACCW  = ACCW_DEF,
  parameter int OBITS = OBITS_DEF
) (
  input  logic signed [ACCW-1:0]  val,
  input  logic                    relu_en,
  output logic signed [OBITS-1:0] res,
  output logic                    sat
);

  localparam logic signed [ACCW-1:0] MAXV =
    ACCW'((1 << (OBITS - 1)) - 1);
  // Bitwise inverse of the max is the most negative OBITS value.
  localparam logic signed [ACCW-1:0] MINV = ~MAXV;

  logic signed [ACCW-1:0] r;

  always_comb begin
    r = val;
    if (relu_en && val[ACCW-1]) begin
      r = '0;
    end
    res = r[OBITS-1:0];
    sat = 1'b0;
    if (r > MAXV) begin
      res = MAXV[OBITS-1:0];
      sat = 1'b1;
    end else if (r < MINV) begin
      res = MINV[OBITS-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/conv_accum.sv
// Channel accumulator: bias + NCH partial sums, ReLU, saturate, 1 result/group.
// Ports: clock, reset, in_valid/in_ready/in_sum/bias/relu_en, out_valid/out_ready/out_data/out_sat.
module conv_accum
  import packConv::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int OBITS = OBITS_DEF,
  parameter int ACCW  = NBITS + $clog2(NCH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [NBITS-1:0] in_sum,
  input  logic signed [NBITS-1:0] bias,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OBITS-1:0] out_data,
  output logic                    out_sat
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  logic [CW-1:0]           ch_cnt;
  logic signed [ACCW-1:0]  acc;
  logic signed [ACCW-1:0]  sum_x;
  logic signed [ACCW-1:0]  bias_x;
  logic signed [ACCW-1:0]  base;
  logic signed [ACCW-1:0]  next;
  logic signed [OBITS-1:0] res;
  logic                    sat;
  logic                    is_last;
  logic                    accept;

  assign sum_x  = {{(ACCW-NBITS){in_sum[NBITS-1]}}, in_sum};
  assign bias_x = {{(ACCW-NBITS){bias[NBITS-1]}}, bias};
  // First beat of a group starts from the bias instead of acc.
  assign base   = (ch_cnt == '0) ? bias_x : acc;
  assign next   = base + sum_x;

  assign is_last  = (ch_cnt == LAST);
  // Only the last beat needs a free output register.
  assign in_ready = !is_last || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  sat_relu #(
    .ACCW  (ACCW),
    .OBITS (OBITS)
  ) u_sat (
    .val     (next),
    .relu_en (relu_en),
    .res     (res),
    .sat     (sat)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      ch_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (accept) begin
        acc    <= next;
        ch_cnt <= is_last ? '0 : ch_cnt + CW'(1);
      end
      if (accept && is_last) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_sat   <= sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_accum.sv
// Bench for conv_accum: NCH=4 and NCH=1 instances, group-level reference model.
// Directed scenarios with literal expectations, then randomized traffic.
module tb_conv_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        reset;
  logic [1:0]        in_valid;
  logic [1:0]        relu_en;
  logic [1:0]        out_ready;
  logic signed [15:0] in_sum [2];
  logic signed [15:0] bias [2];
  logic              in_ready [2];
  logic              out_valid [2];
  logic              out_sat [2];
  logic signed [7:0] out_data [2];

  conv_accum #(.NCH(4), .OBITS(8)) dut0 (
    .clock(clk), .reset(reset[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_sum(in_sum[0]), .bias(bias[0]), .relu_en(relu_en[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_sat(out_sat[0])
  );

  conv_accum #(.NCH(1), .OBITS(8)) dut1 (
    .clock(clk), .reset(reset[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_sum(in_sum[1]), .bias(bias[1]), .relu_en(relu_en[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_sat(out_sat[1])
  );

  int total = 0;
  int bad   = 0;

  // Model: beats seen in the current group, running bias+sums, result reg.
  int mcnt [2]   = '{0, 0};
  int macc [2]   = '{0, 0};
  bit mvalid [2] = '{0, 0};
  int mdata [2]  = '{0, 0};
  bit msat [2]   = '{0, 0};
  int log_d [2][256];
  bit log_s [2][256];
  int log_n [2]  = '{0, 0};

  task automatic chk(string nm, logic signed [31:0] act,
                     logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void post(int v, bit relu, output int d, output bit s);
    int r;
    r = (relu && v < 0) ? 0 : v;
    s = 1'b0;
    d = r;
    if (r > 127) begin d = 127; s = 1'b1; end
    if (r < -128) begin d = -128; s = 1'b1; end
  endfunction

  always @(negedge clk) begin
    int n;
    bit er;
    bit fin;
    for (int i = 0; i < 2; i++) begin
      n  = (i == 0) ? 4 : 1;
      er = !(mcnt[i] == n - 1 && mvalid[i] && !out_ready[i]);
      chk($sformatf("d%0d_in_ready", i), in_ready[i], er);
      chk($sformatf("d%0d_out_valid", i), out_valid[i], mvalid[i]);
      chk($sformatf("d%0d_out_data", i), out_data[i], mdata[i]);
      chk($sformatf("d%0d_out_sat", i), out_sat[i], msat[i]);
      if (reset[i]) begin
        mcnt[i] = 0; macc[i] = 0; mvalid[i] = 0;
        mdata[i] = 0; msat[i] = 0;
      end else begin
        fin = 1'b0;
        if (in_valid[i] && er) begin
          macc[i] = (mcnt[i] == 0 ? int'(bias[i]) : macc[i])
                    + int'(in_sum[i]);
          mcnt[i]++;
          if (mcnt[i] == n) begin
            post(macc[i], relu_en[i], mdata[i], msat[i]);
            mcnt[i] = 0;
            fin = 1'b1;
            if (log_n[i] < 256) begin
              log_d[i][log_n[i]] = mdata[i];
              log_s[i][log_n[i]] = msat[i];
              log_n[i]++;
            end
          end
        end
        if (fin) mvalid[i] = 1'b1;
        else if (out_ready[i]) mvalid[i] = 1'b0;
      end
    end
  end

  task automatic send(int i, int b, int s, bit r);
    bit ok;
    in_valid[i] = 1'b1;
    bias[i]     = 16'(b);
    in_sum[i]   = 16'(s);
    relu_en[i]  = r;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready[i];
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout dut%0d act=0 exp=1", i);
    end
    in_valid[i] = 1'b0;
  endtask

  task automatic group(int b, int s, bit r);
    for (int k = 0; k < 4; k++) send(0, b, s, r);
  endtask

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_log(string nm, int k, int d, bit s);
    chk({nm, "_data"}, log_d[0][k], d);
    chk({nm, "_sat"}, log_s[0][k], s);
  endtask

  int k;

  initial begin
    reset = 2'b11; in_valid = 2'b00; relu_en = 2'b00; out_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin in_sum[i] = '0; bias[i] = '0; end
    cyc(2);
    reset = 2'b00;
    @(negedge clk);
    chk("rst_in_ready", in_ready[0], 1);
    chk("rst_out_valid", out_valid[0], 0);
    chk("rst_out_data", out_data[0], 0);
    cyc(1);

    k = log_n[0];
    send(0, 10, 1, 0); send(0, 10, 2, 0);
    send(0, 10, 3, 0); send(0, 10, 4, 0);
    @(negedge clk);
    chk("basic_valid", out_valid[0], 1);
    chk("basic_dut_data", out_data[0], 20);
    cyc(1);
    @(negedge clk);
    chk("basic_pulse", out_valid[0], 0);
    cyc(1);
    chk_log("basic", k, 20, 0);

    k = log_n[0];
    group(0, 100, 1); cyc(2);
    chk_log("pos_sat", k, 127, 1);
    group(-50, 5, 1); cyc(2);
    chk_log("relu_zero", k + 1, 0, 0);
    group(-50, 5, 0); cyc(2);
    chk_log("neg_res", k + 2, -30, 0);
    group(0, -100, 0); cyc(2);
    chk_log("neg_sat", k + 3, -128, 1);

    out_ready[0] = 1'b0;
    group(1, 1, 0);
    send(0, 0, 2, 0); send(0, 0, 2, 0); send(0, 0, 2, 0);
    in_valid[0] = 1'b1; in_sum[0] = 16'sd2; relu_en[0] = 1'b0;
    @(negedge clk);
    chk("bp_stall", in_ready[0], 0);
    chk("bp_hold_valid", out_valid[0], 1);
    chk("bp_hold_data", out_data[0], 5);
    cyc(1);
    @(negedge clk);
    chk("bp_stall2", in_ready[0], 0);
    cyc(1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release", in_ready[0], 1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp_keep_valid", out_valid[0], 1);
    chk("bp_new_data", out_data[0], 8);
    cyc(1);
    @(negedge clk);
    chk("bp_drain", out_valid[0], 0);
    cyc(1);

    k = log_n[0];
    send(0, 0, 50, 0); send(0, 0, 50, 0);
    reset[0] = 1'b1;
    cyc(1);
    reset[0] = 1'b0;
    group(0, 1, 0); cyc(2);
    chk("rst_mid_count", log_n[0] - k, 1);
    chk_log("rst_mid", k, 4, 0);

    in_valid[1] = 1'b1; bias[1] = 16'sd3; in_sum[1] = 16'sd7;
    relu_en[1] = 1'b0;
    cyc(1);
    in_sum[1] = -16'sd9;
    @(negedge clk);
    chk("n1_first_valid", out_valid[1], 1);
    chk("n1_first_data", out_data[1], 10);
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("n1_second_valid", out_valid[1], 1);
    chk("n1_second_data", out_data[1], -6);
    cyc(2);

    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        reset[i]     = ($urandom_range(0, 99) == 0);
        in_valid[i]  = ($urandom_range(0, 3) != 0);
        out_ready[i] = ($urandom_range(0, 3) != 0);
        relu_en[i]   = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 3) == 0) in_sum[i] = 16'($urandom);
        else in_sum[i] = 16'(int'($urandom_range(0, 400)) - 200);
        if ($urandom_range(0, 3) == 0) bias[i] = 16'($urandom);
        else bias[i] = 16'(int'($urandom_range(0, 200)) - 100);
      end
      cyc(1);
    end
    reset = 2'b00; in_valid = 2'b00; out_ready = 2'b11;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
